// File: rtl/pio_cmd_pkg.sv
// Shared defaults for the PIO command FIFO: byte width, depth and level width.
package pio_cmd_pkg;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  // Level counter must reach DEPTH itself, hence one bit more than the pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pio_cmd_fifo_mem.sv
// DEPTH x DATA_W simple dual-port register array: synchronous write, async read.
module pio_cmd_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is never reset; validity is tracked by the level counter in the top.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pio_cmd_fifo.sv
// First-word-fall-through FIFO fed by a toggle-strobed PIO byte stream.
// Each level change on pio_strobe pushes pio_data; drops on full set a sticky flag.
module pio_cmd_fifo
  import pio_cmd_pkg::*;
#(
  parameter int DATA_W = pio_cmd_pkg::DATA_W,
  parameter int DEPTH  = pio_cmd_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          pio_data,
  input  logic                       pio_strobe,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       full,
  output logic                       empty,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic             strobe_q;
  logic             push_evt, pop, push_ok, drop;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [DATA_W-1:0] rd_data;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign m_valid = ~empty;
  assign level   = level_q;
  assign overflow = ovf_q;
  // Array contents are unknown after reset; present zero whenever nothing is held.
  assign m_data  = m_valid ? rd_data : '0;

  assign push_evt = (pio_strobe != strobe_q);
  assign pop      = m_valid & m_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok  = push_evt & (~full | pop);
  assign drop     = push_evt & full & ~pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A drop on the clearing edge wins so no lost byte goes unreported.
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
  end

  // State registers; strobe_q tracks the pin during reset so release causes no push.
  always_ff @(posedge clk) begin
    strobe_q <= pio_strobe;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  pio_cmd_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_ok & ~reset),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (pio_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

endmodule
